// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller for the ALU datapath with the {C,S,Z} status register.
// Define ALU_CTRL_MULTISHIFT_EN to iterate shift/rotate ops over shcnt steps.
module alu_ctrl #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] shcnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [2:0]       status,
  output logic             trap
);
  localparam int H = WIDTH / 2;
  localparam logic [4:0] OP_NOT = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3, OP_XOR = 5'd4,
    OP_SHR = 5'd5, OP_SHL = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_SWAP = 5'd9,
    OP_INC = 5'd10, OP_DEC = 5'd11, OP_ADD = 5'd12, OP_ADC = 5'd13, OP_SUB = 5'd14,
    OP_SBC = 5'd15, OP_EQ = 5'd16, OP_GT = 5'd17, OP_LT = 5'd18, OP_GE = 5'd19,
    OP_LE = 5'd20, OP_LSR = 5'd21, OP_XSR = 5'd22;
`ifdef ALU_CTRL_MULTISHIFT_EN
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  logic unused_shcnt;
  assign unused_shcnt = ^shcnt;
`endif
  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic             mode_q, mode_d, trap_q, trap_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, resb_q, resb_d;
  logic [2:0]       st_q, st_d;
  logic [WIDTH-1:0] mask, sr, step_r, y, sum_r, ex_r;
  logic [WIDTH:0]   sum;
  logic             top, step_c, cin, cout, cond, is_sh;
  logic [2:0]       step_f, rf, ex_f;

  function automatic logic [WIDTH-1:0] msk(input logic m);
    return m ? {WIDTH{1'b1}} : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  endfunction

  function automatic logic msb(input logic m, input logic [WIDTH-1:0] r);
    return m ? r[WIDTH-1] : r[H-1];
  endfunction

  // Shift step works on a_q in EXEC and on the running result in SHIFT
  always_comb begin
    mask   = msk(mode_q);
    is_sh  = op_q inside {[OP_SHR:OP_ROL]};
    sr     = (state_q == EXEC) ? a_q : res_q;
    top    = msb(mode_q, sr);
    step_r = op_q == OP_SHR ? (sr << 1) & mask :
             op_q == OP_SHL ? sr >> 1 :
             op_q == OP_ROR ? ((sr << 1) | WIDTH'(top)) & mask :
             (sr >> 1) | (mode_q ? {sr[0], {(WIDTH-1){1'b0}}} : WIDTH'(sr[0]) << (H-1));
    step_c = op_q == OP_SHR ? top : op_q == OP_SHL ? sr[0] : st_q[2];
    step_f = {step_c, msb(mode_q, step_r), step_r == '0};
  end

  // Subtracts add the masked complement so the carry lands at the active width
  always_comb begin
    y   = '0;
    cin = 1'b0;
    case (op_q)
      OP_INC: cin = 1'b1;
      OP_DEC: y = mask;
      OP_ADD: y = b_q;
      OP_ADC: begin y = b_q; cin = st_q[2]; end
      OP_SUB: begin y = ~b_q & mask; cin = 1'b1; end
      OP_SBC: begin y = ~b_q & mask; cin = ~st_q[2]; end
      default: ;
    endcase
    sum   = {1'b0, a_q} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    sum_r = sum[WIDTH-1:0] & mask;
    cout  = mode_q ? sum[WIDTH] : sum[H];
    cond  = op_q == OP_EQ ? a_q == b_q : op_q == OP_GT ? a_q > b_q :
            op_q == OP_LT ? a_q < b_q : op_q == OP_GE ? a_q >= b_q : a_q <= b_q;
    case (op_q)
      OP_NOT:  ex_r = ~a_q & mask;
      OP_AND:  ex_r = a_q & b_q;
      OP_OR:   ex_r = a_q | b_q;
      OP_XOR:  ex_r = a_q ^ b_q;
      OP_SWAP: ex_r = b_q;
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC: ex_r = sum_r;
      default: ex_r = '0;
    endcase
    rf   = {st_q[2], msb(mode_q, ex_r), ex_r == '0};
    ex_f = (op_q inside {[OP_NOT:OP_XOR]}) ? rf :
           (op_q inside {[OP_INC:OP_SBC]}) ? {(op_q >= OP_SUB) ? ~cout : cout, rf[1:0]} :
           (op_q inside {[OP_EQ:OP_LE]}) ? {st_q[2], ~cond, cond} :
           op_q == OP_LSR ? a_q[2:0] : op_q == OP_XSR ? st_q ^ a_q[2:0] : st_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    resb_d  = resb_q;
    st_d    = st_q;
    trap_d  = trap_q;
`ifdef ALU_CTRL_MULTISHIFT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = op;
        mode_d  = mode;
        a_d     = a & msk(mode);
        b_d     = b & msk(mode);
        trap_d  = op > OP_XSR;
`ifdef ALU_CTRL_MULTISHIFT_EN
        cnt_d   = shcnt;
`endif
        state_d = EXEC;
      end
      EXEC: begin
        resb_d  = (op_q == OP_SWAP) ? a_q : '0;
        state_d = DONE;
        if (is_sh) begin
`ifdef ALU_CTRL_MULTISHIFT_EN
          if (cnt_q == '0) res_d = a_q;
          else begin
            res_d = step_r;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q > CNT_W'(1)) state_d = SHIFT;
            else st_d = step_f;
          end
`else
          res_d = step_r;
          st_d  = step_f;
`endif
        end else begin
          res_d = ex_r;
          st_d  = ex_f;
        end
      end
`ifdef ALU_CTRL_MULTISHIFT_EN
      SHIFT: begin
        res_d = step_r;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          st_d    = step_f;
          state_d = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      resb_q  <= '0;
      st_q    <= '0;
      trap_q  <= 1'b0;
`ifdef ALU_CTRL_MULTISHIFT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      resb_q  <= resb_d;
      st_q    <= st_d;
      trap_q  <= trap_d;
`ifdef ALU_CTRL_MULTISHIFT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign res_a     = res_q;
  assign res_b     = resb_q;
  assign status    = st_q;
  assign trap      = trap_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed self-checking bench for alu_ctrl (both ALU_CTRL_MULTISHIFT_EN builds).
module tb_alu_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b1, out_ready = 1'b0;
  logic        in_ready, out_valid, trap;
  logic [4:0]  op = '0, shcnt = '0;
  logic [19:0] a = '0, b = '0, res_a, res_b;
  logic [2:0]  status;
  int          compared = 0, mismatched = 0, lat;

  alu_ctrl #(.WIDTH(20), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .mode(mode), .a(a), .b(b), .shcnt(shcnt), .out_valid(out_valid),
    .out_ready(out_ready), .res_a(res_a), .res_b(res_b), .status(status), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [4:0] o, input logic m, input logic [19:0] xa,
                       input logic [19:0] xb, input logic [4:0] n);
    @(negedge clk);
    op = o; mode = m; a = xa; b = xb; shcnt = n; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // l counts cycles from the accept cycle (cycle 0) to the first cycle with out_valid
  task automatic run(input logic [4:0] o, input logic m, input logic [19:0] xa,
                     input logic [19:0] xb, input logic [4:0] n, output int l);
    start(o, m, xa, xb, n);
    l = 1;
    while (!out_valid && l < 64) begin
      @(posedge clk);
      #1 l++;
    end
    chk("out_valid_seen", out_valid, 1);
    @(negedge clk);
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res_a", res_a, 0);
    chk("rst_res_b", res_b, 0);
    chk("rst_status", status, 3'b000);
    chk("rst_trap", trap, 0);
    rst_n = 1'b1;

    run(5'd12, 1'b1, 20'hFFFFF, 20'h00001, 5'd0, lat);
    chk("add_res", res_a, 20'h00000);
    chk("add_status", status, 3'b101);
    chk("add_lat", lat, 2);
    chk("add_in_ready", in_ready, 0);
    release_out();
    chk("add_back_idle", in_ready, 1);

    run(5'd14, 1'b0, 20'h00005, 20'h00007, 5'd0, lat);
    chk("sub_half_res", res_a, 20'h003FE);
    chk("sub_half_status", status, 3'b110);
    release_out();

    run(5'd7, 1'b1, 20'h80001, 20'h0, 5'd3, lat);
`ifdef ALU_CTRL_MULTISHIFT_EN
    chk("ror3_res", res_a, 20'h0000C);
    chk("ror3_lat", lat, 4);
`else
    chk("ror3_res", res_a, 20'h00003);
    chk("ror3_lat", lat, 2);
`endif
    chk("ror3_status", status, 3'b100);
    release_out();

    run(5'd7, 1'b1, 20'h80001, 20'h0, 5'd0, lat);
`ifdef ALU_CTRL_MULTISHIFT_EN
    chk("ror0_res", res_a, 20'h80001);
`else
    chk("ror0_res", res_a, 20'h00003);
`endif
    chk("ror0_status", status, 3'b100);
    chk("ror0_lat", lat, 2);
    release_out();

    run(5'd5, 1'b0, 20'h00201, 20'h0, 5'd1, lat);
    chk("shr_half_res", res_a, 20'h00002);
    chk("shr_half_status", status, 3'b100);
    chk("shr_half_lat", lat, 2);
    release_out();

    run(5'd21, 1'b1, 20'h00005, 20'h0, 5'd0, lat);
    chk("lsr_status", status, 3'b101);
    chk("lsr_res", res_a, 0);
    release_out();
    run(5'd22, 1'b1, 20'h00007, 20'h0, 5'd0, lat);
    chk("xsr_status", status, 3'b010);
    release_out();
    run(5'd13, 1'b1, 20'h00001, 20'h00001, 5'd0, lat);
    chk("adc_res", res_a, 20'h00002);
    chk("adc_status", status, 3'b000);
    release_out();

    run(5'd25, 1'b1, 20'h12345, 20'h54321, 5'd0, lat);
    chk("ill_trap", trap, 1);
    chk("ill_res", res_a, 0);
    chk("ill_status", status, 3'b000);
    release_out();
    chk("ill_trap_held", trap, 1);

    run(5'd2, 1'b1, 20'hFF00F, 20'h8F0FF, 5'd0, lat);
    chk("and_res", res_a, 20'h8F00F);
    chk("and_status", status, 3'b010);
    chk("and_trap_clear", trap, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_res", res_a, 20'h8F00F);
      chk("hold_status", status, 3'b010);
    end
    release_out();

    run(5'd9, 1'b1, 20'h12345, 20'h0ABCD, 5'd0, lat);
    chk("swap_res_a", res_a, 20'h0ABCD);
    chk("swap_res_b", res_b, 20'h12345);
    chk("swap_status", status, 3'b010);
    release_out();

    run(5'd18, 1'b1, 20'h00003, 20'h00005, 5'd0, lat);
    chk("lt_res", res_a, 0);
    chk("lt_res_b", res_b, 0);
    chk("lt_status", status, 3'b001);
    release_out();

    run(5'd21, 1'b1, 20'h00007, 20'h0, 5'd0, lat);
    chk("lsr7_status", status, 3'b111);
    release_out();
    start(5'd6, 1'b1, 20'h00001, 20'h0, 5'd10);
`ifdef ALU_CTRL_MULTISHIFT_EN
    repeat (2) @(posedge clk);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_status", status, 3'b000);
    chk("midrst_res", res_a, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst_discarded", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
